// File: rtl/elevator_pkg.sv
// elevator_pkg: shared constants and the scheduler state encoding for the
// 7-floor elevator car sequencer.
//   FLOOR_MIN / FLOOR_MAX : the floor range the car may ever occupy (1..7)
//   DIR_*                 : current_direction encodings (11 never driven)
//   OPEN/CLOSE, MOVE/HOLD, ON/OFF : single-bit output levels
//   BTN_DOOR_OPEN/CLOSE   : bit positions in the car panel vector
//   elevState_t           : scheduler FSM states
package elevator_pkg;

  localparam logic [2:0] FLOOR_MIN = 3'd1;
  localparam logic [2:0] FLOOR_MAX = 3'd7;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic MOVE  = 1'b1;
  localparam logic HOLD  = 1'b0;
  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;

  localparam int BTN_DOOR_OPEN  = 8;
  localparam int BTN_DOOR_CLOSE = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_OPEN   = 2'd2
  } elevState_t;

endpackage

// File: rtl/elevator_request_scan.sv
// elevator_request_scan: purely combinational summary of outstanding calls
// relative to one floor.
//   floor_button [13:0] : hall calls, bit 2*(f-1) = up at f, bit 2*(f-1)+1 = down at f
//   carButton    [7:1]  : car panel floor calls
//   floorNum     [2:0]  : reference floor (1..7; 0 has no calls)
//   here     : any call at floorNum
//   above    : any call at a floor > floorNum
//   below    : any call at a floor < floorNum
//   upHere   : up hall call at floorNum
//   downHere : down hall call at floorNum
module elevator_request_scan
  import elevator_pkg::*;
(
  input  logic [13:0] floor_button,
  input  logic [7:1]  carButton,
  input  logic [2:0]  floorNum,
  output logic        here,
  output logic        above,
  output logic        below,
  output logic        upHere,
  output logic        downHere
);

  logic [7:1] upCall;
  logic [7:1] downCall;
  logic [7:0] reqVec;
  logic [7:0] upVec;
  logic [7:0] downVec;
  logic [7:0] lowMask;

  for (genvar f = 1; f <= 7; f++) begin : gCall
    assign upCall[f]   = floor_button[2*f-2];
    assign downCall[f] = floor_button[2*f-1];
  end

  // Bit 0 stands for the nonexistent floor 0 and is tied low, so a
  // reference of 0 sees no call "here" and everything counts as above.
  assign reqVec  = {carButton | upCall | downCall, 1'b0};
  assign upVec   = {upCall, 1'b0};
  assign downVec = {downCall, 1'b0};
  assign lowMask = (8'd1 << floorNum) - 8'd1;

  assign here     = reqVec[floorNum];
  assign upHere   = upVec[floorNum];
  assign downHere = downVec[floorNum];
  assign above    = |((reqVec >> floorNum) >> 1);
  assign below    = |(reqVec & lowMask);

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN (collective-selective) car motion and door
// sequencer for a 7-floor car.
//   clk, reset        : clock, synchronous active-high reset
//   floor_button[13:0]: latched hall calls (up/down pairs per floor)
//   internal_button[9:1]: car panel, 1..7 floors, 8 door-open, 9 door-close
//   current_floor[2:0]: floor 1..7
//   current_direction : 01 up, 10 down, 00 none
//   door_state        : 1 open, 0 closed
//   move              : 1 travelling, 0 holding
// All outputs are registered; door_state and move decode the state register.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8,
  parameter int TIMER_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] floor_button,
  input  logic [9:1]  internal_button,
  output logic [2:0]  current_floor,
  output logic [1:0]  current_direction,
  output logic        door_state,
  output logic        move
);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  elevState_t         state, stateD;
  logic [2:0]         floorQ, floorD;
  logic [1:0]         dirQ, dirD;
  logic [TIMER_W-1:0] timerQ, timerD;

  logic       cHere, cAbove, cBelow, cUpHere, cDownHere;
  logic       unusedNextHere, nAbove, nBelow, nUpHere, nDownHere;
  logic [2:0] stepFloor;
  logic [7:0] carVec;
  logic       goingUp, carNext, beyondNext, inDirNext, oppNext, atEnd, stopNext;
  logic       openHold, closeNow;

  assign goingUp   = (dirQ == DIR_UP);
  assign stepFloor = goingUp ? floorQ + 3'd1 : floorQ - 3'd1;
  assign carVec    = {internal_button[7:1], 1'b0};

  elevator_request_scan uScanCur (
    .floor_button (floor_button),
    .carButton    (internal_button[7:1]),
    .floorNum     (floorQ),
    .here         (cHere),
    .above        (cAbove),
    .below        (cBelow),
    .upHere       (cUpHere),
    .downHere     (cDownHere)
  );

  // Evaluates the floor the car is about to arrive at, so the stop decision
  // lands on the same edge as the floor update.
  elevator_request_scan uScanNext (
    .floor_button (floor_button),
    .carButton    (internal_button[7:1]),
    .floorNum     (stepFloor),
    .here         (unusedNextHere),
    .above        (nAbove),
    .below        (nBelow),
    .upHere       (nUpHere),
    .downHere     (nDownHere)
  );

  assign carNext    = carVec[stepFloor];
  assign beyondNext = goingUp ? nAbove : nBelow;
  assign inDirNext  = goingUp ? nUpHere : nDownHere;
  assign oppNext    = goingUp ? nDownHere : nUpHere;
  assign atEnd      = (goingUp && stepFloor == FLOOR_MAX) ||
                      (!goingUp && stepFloor == FLOOR_MIN);
  assign stopNext   = carNext || inDirNext || !beyondNext || atEnd;

  // Door-open beats door-close when both are pressed.
  assign openHold = internal_button[BTN_DOOR_OPEN];
  assign closeNow = internal_button[BTN_DOOR_CLOSE] && !openHold;

  always_comb begin
    stateD = state;
    floorD = floorQ;
    dirD   = dirQ;
    timerD = timerQ;
    case (state)
      ST_IDLE: begin
        if (cHere) begin
          stateD = ST_OPEN;
          timerD = DOOR_LOAD;
          dirD   = cUpHere ? DIR_UP : (cDownHere ? DIR_DOWN : DIR_NONE);
        end else if (cAbove) begin
          stateD = ST_MOVING;
          dirD   = DIR_UP;
          timerD = TRAVEL_LOAD;
        end else if (cBelow) begin
          stateD = ST_MOVING;
          dirD   = DIR_DOWN;
          timerD = TRAVEL_LOAD;
        end
      end
      ST_MOVING: begin
        if (timerQ == TIMER_ONE) begin
          floorD = stepFloor;
          if (stopNext) begin
            stateD = ST_OPEN;
            timerD = DOOR_LOAD;
            // End of the run with only the opposite hall call waiting:
            // turn around now so the button block clears that call.
            if (!beyondNext && !inDirNext && oppNext)
              dirD = goingUp ? DIR_DOWN : DIR_UP;
          end else begin
            timerD = TRAVEL_LOAD;
          end
        end else begin
          timerD = timerQ - TIMER_ONE;
        end
      end
      ST_OPEN: begin
        if (openHold) begin
          timerD = DOOR_LOAD;
        end else if (closeNow || timerQ == TIMER_ONE) begin
          // Keep the current heading if work remains that way (no heading
          // prefers up), otherwise reverse, otherwise serve a late call here.
          if (dirQ != DIR_DOWN && cAbove) begin
            stateD = ST_MOVING;
            dirD   = DIR_UP;
            timerD = TRAVEL_LOAD;
          end else if (dirQ == DIR_DOWN && cBelow) begin
            stateD = ST_MOVING;
            dirD   = DIR_DOWN;
            timerD = TRAVEL_LOAD;
          end else if (cAbove) begin
            stateD = ST_MOVING;
            dirD   = DIR_UP;
            timerD = TRAVEL_LOAD;
          end else if (cBelow) begin
            stateD = ST_MOVING;
            dirD   = DIR_DOWN;
            timerD = TRAVEL_LOAD;
          end else if (cHere) begin
            // Reopen; adopt the direction of a waiting hall call so it can
            // be cleared, keeping the heading if its own call is waiting.
            stateD = ST_OPEN;
            timerD = DOOR_LOAD;
            if (!((dirQ == DIR_UP && cUpHere) || (dirQ == DIR_DOWN && cDownHere))) begin
              if (cUpHere)
                dirD = DIR_UP;
              else if (cDownHere)
                dirD = DIR_DOWN;
            end
          end else begin
            stateD = ST_IDLE;
            dirD   = DIR_NONE;
          end
        end else begin
          timerD = timerQ - TIMER_ONE;
        end
      end
      default: begin
        stateD = ST_IDLE;
        dirD   = DIR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      floorQ <= FLOOR_MIN;
      dirQ   <= DIR_NONE;
      timerQ <= '0;
    end else begin
      state  <= stateD;
      floorQ <= floorD;
      dirQ   <= dirD;
      timerQ <= timerD;
    end
  end

  assign current_floor     = floorQ;
  assign current_direction = dirQ;
  assign door_state        = (state == ST_OPEN) ? OPEN : CLOSE;
  assign move              = (state == ST_MOVING) ? MOVE : HOLD;

endmodule
